// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - N-LED active-low pattern sequencer with rotate, bounce and fill-bar modes.
// Fill-bar mode is built only when LED_SEQUENCER_FILL_EN is defined; otherwise mode 3 rotates up.
module led_sequencer #(
  parameter int NUM_LEDS    = 6,
  parameter int STEP_CYCLES = 4500000,
  parameter int CNT_W       = 32,
  localparam int POS_W      = $clog2(NUM_LEDS + 1)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [1:0]          mode_i,
  input  logic [1:0]          speed_i,
  input  logic                pause_i,
  output logic [NUM_LEDS-1:0] leds_o,
  output logic [POS_W-1:0]    pos_o,
  output logic                tick_o
);

  localparam logic [1:0] MODE_UP     = 2'd0;
  localparam logic [1:0] MODE_DOWN   = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_FILL   = 2'd3;

  localparam logic [POS_W-1:0] LAST = POS_W'(NUM_LEDS - 1);
  localparam logic [POS_W-1:0] ONE  = POS_W'(1);
`ifdef LED_SEQUENCER_FILL_EN
  localparam logic [POS_W-1:0] FULL = POS_W'(NUM_LEDS);
`endif

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;  // 1 = moving down (bounce only)
  logic [1:0]       cur_mode_q, cur_mode_d;
  logic             tick_q, tick_d;

  logic [CNT_W-1:0]    period_m1;
  logic                terminal;
  logic [NUM_LEDS-1:0] lit;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q      <= '0;
      pos_q      <= '0;
      dir_q      <= 1'b0;
      cur_mode_q <= MODE_UP;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      pos_q      <= pos_d;
      dir_q      <= dir_d;
      cur_mode_q <= cur_mode_d;
      tick_q     <= tick_d;
    end
  end

  // >= rather than == so that shortening the period mid-count fires on the next clock.
  assign period_m1 = (CNT_W'(STEP_CYCLES) >> speed_i) - CNT_W'(1);
  assign terminal  = (cnt_q >= period_m1);

  always_comb begin
    cnt_d      = cnt_q;
    pos_d      = pos_q;
    dir_d      = dir_q;
    cur_mode_d = cur_mode_q;
    tick_d     = 1'b0;
    if (!pause_i) begin
      if (terminal) begin
        cnt_d      = '0;
        tick_d     = 1'b1;
        cur_mode_d = mode_i;
        if (mode_i != cur_mode_q) begin
          pos_d = (mode_i == MODE_DOWN) ? LAST : '0;
          dir_d = 1'b0;
        end else begin
          case (cur_mode_q)
            MODE_DOWN: begin
              pos_d = (pos_q == '0 || pos_q > LAST) ? LAST : pos_q - ONE;
            end
            MODE_BOUNCE: begin
              if (!dir_q) begin
                if (pos_q >= LAST) begin
                  pos_d = LAST - ONE;
                  dir_d = 1'b1;
                end else begin
                  pos_d = pos_q + ONE;
                  dir_d = (pos_q + ONE == LAST);
                end
              end else begin
                if (pos_q == '0) begin
                  pos_d = ONE;
                  dir_d = 1'b0;
                end else begin
                  pos_d = pos_q - ONE;
                  dir_d = (pos_q != ONE);
                end
              end
            end
`ifdef LED_SEQUENCER_FILL_EN
            MODE_FILL: begin
              pos_d = (pos_q >= FULL) ? '0 : pos_q + ONE;
            end
`endif
            default: begin
              pos_d = (pos_q >= LAST) ? '0 : pos_q + ONE;
            end
          endcase
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    lit = NUM_LEDS'(1) << pos_q;
`ifdef LED_SEQUENCER_FILL_EN
    if (cur_mode_q == MODE_FILL) begin
      lit = ~({NUM_LEDS{1'b1}} << pos_q);
    end
`endif
  end

  // Lamp test: every LED lit while reset is held.
  assign leds_o = reset_i ? ~lit : {NUM_LEDS{1'b0}};
  assign pos_o  = pos_q;
  assign tick_o = tick_q;

endmodule

// File: tb/tb_led_sequencer.sv
// tb/tb_led_sequencer.sv - directed self-checking bench for led_sequencer (6 LEDs, 5-cycle step).
module tb_led_sequencer;

  localparam int N = 6;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [1:0] mode_i;
  logic [1:0] speed_i;
  logic       pause_i;
  logic [5:0] leds_o;
  logic [2:0] pos_o;
  logic       tick_o;

  int n_tests = 0;
  int n_fail  = 0;

  led_sequencer #(.NUM_LEDS(6), .STEP_CYCLES(5), .CNT_W(8)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .mode_i  (mode_i),
    .speed_i (speed_i),
    .pause_i (pause_i),
    .leds_o  (leds_o),
    .pos_o   (pos_o),
    .tick_o  (tick_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic wait_tick(output int edges, output bit ok);
    edges = 0;
    ok    = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk_i);
      #1;
      edges++;
      if (tick_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int edges;
    bit ok;
    logic [5:0] exp;
    reset_i = 1'b0; mode_i = 2'd0; speed_i = 2'd0; pause_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    n_tests++;
    if (leds_o !== 6'b000000 || pos_o !== 3'd0 || tick_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: leds=%b pos=%0d tick=%b, want 000000/0/0", leds_o, pos_o, tick_o);
    end
    reset_i = 1'b1;
    #1;
    n_tests++;
    if (leds_o !== 6'b111110) begin
      n_fail++;
      $display("FAIL release_leds: got %b want 111110", leds_o);
    end
    for (int k = 0; k < 6; k++) begin
      wait_tick(edges, ok);
      exp = ~(6'b1 << ((k + 1) % N));
      n_tests++;
      if (!ok || edges != 5 || leds_o !== exp) begin
        n_fail++;
        $display("FAIL rotate_up[%0d]: ok=%b edges=%0d leds=%b, want edges=5 leds=%b", k, ok, edges, leds_o, exp);
      end
    end
  endtask

  task automatic test_bounce;
    int edges;
    bit ok;
    int exp_seq[20] = '{1,2,3,4,5,4,3,2,1,0,1,2,3,4,5,4,3,2,1,0};
    mode_i = 2'd2;
    wait_tick(edges, ok);
    n_tests++;
    if (!ok || pos_o !== 3'd0) begin
      n_fail++;
      $display("FAIL bounce_start: ok=%b pos=%0d want 0", ok, pos_o);
    end
    for (int k = 0; k < 20; k++) begin
      wait_tick(edges, ok);
      n_tests++;
      if (!ok || pos_o !== 3'(exp_seq[k]) || leds_o !== ~(6'b1 << exp_seq[k])) begin
        n_fail++;
        $display("FAIL bounce[%0d]: ok=%b pos=%0d leds=%b, want pos=%0d", k, ok, pos_o, leds_o, exp_seq[k]);
      end
    end
  endtask

  task automatic test_fill;
    int edges;
    bit ok;
    int p;
    logic [5:0] exp;
    mode_i = 2'd3;
    wait_tick(edges, ok);
`ifdef LED_SEQUENCER_FILL_EN
    exp = 6'b111111;
`else
    exp = 6'b111110;
`endif
    n_tests++;
    if (!ok || pos_o !== 3'd0 || leds_o !== exp) begin
      n_fail++;
      $display("FAIL mode3_start: ok=%b pos=%0d leds=%b, want 0/%b", ok, pos_o, leds_o, exp);
    end
    for (int k = 0; k < 7; k++) begin
      wait_tick(edges, ok);
`ifdef LED_SEQUENCER_FILL_EN
      p   = (k + 1) % (N + 1);
      exp = ~((6'b1 << p) - 6'b1);
      if (p == 6) exp = 6'b000000;
`else
      p   = (k + 1) % N;
      exp = ~(6'b1 << p);
`endif
      n_tests++;
      if (!ok || pos_o !== 3'(p) || leds_o !== exp) begin
        n_fail++;
        $display("FAIL mode3[%0d]: ok=%b pos=%0d leds=%b, want pos=%0d leds=%b", k, ok, pos_o, leds_o, p, exp);
      end
    end
  endtask

  task automatic test_speed;
    int edges;
    bit ok;
    mode_i = 2'd0;
    wait_tick(edges, ok);
    n_tests++;
    if (!ok || pos_o !== 3'd0) begin
      n_fail++;
      $display("FAIL speed_restart: ok=%b pos=%0d want 0", ok, pos_o);
    end
    repeat (3) @(posedge clk_i);
    #1;
    speed_i = 2'd2;
    wait_tick(edges, ok);
    n_tests++;
    if (!ok || edges != 1 || pos_o !== 3'd1) begin
      n_fail++;
      $display("FAIL speed_up_fire: ok=%b edges=%0d pos=%0d, want 1/1", ok, edges, pos_o);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_i);
      #1;
      n_tests++;
      if (tick_o !== 1'b1 || pos_o !== 3'(k + 2)) begin
        n_fail++;
        $display("FAIL speed2_period[%0d]: tick=%b pos=%0d, want 1/%0d", k, tick_o, pos_o, k + 2);
      end
    end
    speed_i = 2'd0;
  endtask

  task automatic test_pause;
    int edges;
    bit ok;
    int ticks_seen;
    logic [2:0] p;
    wait_tick(edges, ok);
    n_tests++;
    if (!ok || edges != 5) begin
      n_fail++;
      $display("FAIL pause_sync: ok=%b edges=%0d want 5", ok, edges);
    end
    p = pos_o;
    repeat (2) @(posedge clk_i);
    #1;
    pause_i = 1'b1;
    ticks_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk_i);
      #1;
      if (tick_o || pos_o !== p) ticks_seen++;
    end
    n_tests++;
    if (ticks_seen != 0) begin
      n_fail++;
      $display("FAIL pause_hold: %0d disturbed cycles, want 0", ticks_seen);
    end
    pause_i = 1'b0;
    wait_tick(edges, ok);
    n_tests++;
    if (!ok || edges != 3 || pos_o !== 3'((p + 1) % N)) begin
      n_fail++;
      $display("FAIL pause_resume: ok=%b edges=%0d pos=%0d, want 3/%0d", ok, edges, pos_o, (p + 1) % N);
    end
    p = pos_o;
    repeat (4) @(posedge clk_i);
    #1;
    pause_i = 1'b1;
    @(posedge clk_i);
    #1;
    n_tests++;
    if (tick_o !== 1'b0 || pos_o !== p) begin
      n_fail++;
      $display("FAIL pause_terminal: tick=%b pos=%0d, want 0/%0d", tick_o, pos_o, p);
    end
    pause_i = 1'b0;
    @(posedge clk_i);
    #1;
    n_tests++;
    if (tick_o !== 1'b1 || pos_o !== 3'((p + 1) % N)) begin
      n_fail++;
      $display("FAIL pause_terminal_resume: tick=%b pos=%0d, want 1/%0d", tick_o, pos_o, (p + 1) % N);
    end
  endtask

  task automatic test_mode_change;
    int edges;
    bit ok;
    bit found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      if (pos_o === 3'd2) found = 1'b1;
      else wait_tick(edges, ok);
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL reach_pos2: pos=%0d want 2", pos_o);
    end
    mode_i = 2'd1;
    wait_tick(edges, ok);
    n_tests++;
    if (!ok || pos_o !== 3'd5 || leds_o !== 6'b011111) begin
      n_fail++;
      $display("FAIL down_start: ok=%b pos=%0d leds=%b, want 5/011111", ok, pos_o, leds_o);
    end
    wait_tick(edges, ok);
    n_tests++;
    if (!ok || pos_o !== 3'd4) begin
      n_fail++;
      $display("FAIL down_step: ok=%b pos=%0d want 4", ok, pos_o);
    end
    repeat (2) @(posedge clk_i);
    #3;
    reset_i = 1'b0;
    #1;
    n_tests++;
    if (leds_o !== 6'b000000 || pos_o !== 3'd0 || tick_o !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: leds=%b pos=%0d tick=%b, want 000000/0/0", leds_o, pos_o, tick_o);
    end
    @(posedge clk_i);
    #1;
    reset_i = 1'b1;
    mode_i  = 2'd0;
    wait_tick(edges, ok);
    n_tests++;
    if (!ok || edges != 5 || pos_o !== 3'd1) begin
      n_fail++;
      $display("FAIL post_reset_tick: ok=%b edges=%0d pos=%0d, want 5/1", ok, edges, pos_o);
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_fill();
    test_speed();
    test_pause();
    test_mode_change();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Parametrised LED sequencer for the board's user LEDs. It generates a step tick from the system clock and drives an N-LED active-low pattern. Four run modes are available: rotate up, rotate down, bounce, and fill bar. A speed select and a pause input control stepping. It sits directly between the clock/reset pins and the LED pins in the top level.

## Interface
- `NUM_LEDS`, 6: number of LEDs driven; legal range 2..32.
- `STEP_CYCLES`, 4500000: clock cycles per step at speed 0; must be ≥ 8.
- `CNT_W`, 32: width of the step counter; must hold `STEP_CYCLES`.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset (0 = reset, 1 = run).
- `mode` in 2: 0 = rotate up, 1 = rotate down, 2 = bounce, 3 = fill bar.
- `speed` in 2: step period is `STEP_CYCLES >> speed`, giving 1x, 2x, 4x or 8x.
- `pause` in 1: while 1, the step counter holds and no steps occur.
- `leds` out `NUM_LEDS`: active-low LED drive (0 = lit).
- `pos` out `$clog2(NUM_LEDS+1)`: current position, or fill count in fill mode.
- `tick` out 1: one-cycle pulse on every step.

## Operation
- Step counter `cnt`:
  - Increments each clock while `pause` = 0.
  - When `cnt >= (STEP_CYCLES >> speed) - 1`, it returns to 0, `tick` = 1 for that cycle, and the state advances.
  - The `>=` compare ensures a speed increase mid-period never overruns; the step fires on the next clock.
- Mode latch `cur_mode`:
  - Loaded from `mode` on each tick.
  - If `mode` ≠ `cur_mode` at a tick, the state is loaded with the start state of the new mode; no normal advance occurs on that tick.
  - Start states: up, bounce and fill → `pos` = 0, `dir` = up. Down → `pos` = `NUM_LEDS-1`.
- Rotate up: `pos` goes 0 → `NUM_LEDS-1` and wraps to 0. Exactly LED[`pos`] is lit.
- Rotate down: `pos` goes `NUM_LEDS-1` → 0 and wraps to `NUM_LEDS-1`. Exactly LED[`pos`] is lit.
- Bounce:
  - Sequence is 0, 1, …, N-1, N-2, …, 1, 0, 1, …; period 2N-2 steps.
  - `dir` flips on the step that reaches an endpoint, so endpoints are not repeated.
  - Exactly LED[`pos`] is lit.
- Fill:
  - `pos` counts 0..`NUM_LEDS`; LED[i] is lit iff i < `pos`.
  - After `pos` = `NUM_LEDS`, the next step returns it to 0 (all dark); N+1 states.
- `leds` is derived combinationally from the registered state: `leds = reset ? ~lit : {NUM_LEDS{1'b0}}`. All LEDs are lit while reset is held (lamp test).
- `pause` and `speed` have no effect on the pattern other than timing.

## Timing
- Reset (async, on `reset` falling):
  - `cnt` = 0, `pos` = 0, `dir` = up, `cur_mode` = 0, `tick` = 0.
  - `leds` = all 0 while held.
- After release, the first tick occurs on the `(STEP_CYCLES>>speed)`-th rising edge with `pause` = 0.
- `pos` and `leds` update on the same edge that registers `tick` = 1.
- Reset mid-sequence aborts immediately; no partial step completes.
- `pause` rising on the terminal-count cycle: that step is suppressed and `cnt` holds its value.
- `pause` falling: counting resumes from the held `cnt`.
- A mode change and a terminal count on the same edge: the new mode's start state is loaded, not an advance.

## Configuration
- Macro: `LED_SEQUENCER_FILL_EN`.
- Defined: fill mode is implemented as above, and `pos` is `$clog2(NUM_LEDS+1)` bits.
- Undefined:
  - Fill logic is omitted.
  - `mode` = 3 behaves exactly as mode 0 (rotate up), including the mode-change restart rule, which treats 3 and 0 as distinct codes.
  - `pos` width is unchanged.

## Test plan
All scenarios use `NUM_LEDS` = 6 and `STEP_CYCLES` = 5.
- Reset low → `leds` = 6'b000000, `pos` = 0, `tick` = 0. Release with mode 0, speed 0 → `tick` pulses every 5 clocks. `leds` sequence: 111110, 111101, …, 011111, 111110 (wrap).
- Mode 2, 20 ticks → `pos` sequence 0,1,2,3,4,5,4,3,2,1,0,1,…, with no endpoint repeats.
- Mode 3 with `LED_SEQUENCER_FILL_EN` defined → `leds` 111111, 111110, 111100, …, 000000, 111111. Without the macro → identical to the mode 0 sequence.
- Speed 0→2 while `cnt` = 3 → `tick` fires on the next clock. Thereafter the period is 1 clock (`5>>2` = 1).
- `pause` = 1 for 12 clocks mid-period → no `tick` and `pos` stable. After `pause` drops, the tick arrives after the remaining count.
- Switch mode 0→1 at `pos` = 2 → the next tick loads `pos` = 5, and the following tick gives `pos` = 4. Assert reset mid-period → outputs return to reset values asynchronously.
